// File: rtl/fcc_pkg.sv
// Shared widths, background label, scanner state encoding and window record for the FCC labelling path.
package fcc_pkg;
  localparam int LABEL_W = 16;
  localparam int COL_W   = 5;
  localparam logic [LABEL_W-1:0] BG_LABEL = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [7:0]         row;
    logic [COL_W-1:0]   col;
    logic [LABEL_W-1:0] label;
    logic               is_ground;
  } window_t;
endpackage

// File: rtl/fcc_skid_fifo.sv
// Two-entry FIFO between the memory read port and the window stream; push is never refused.
module fcc_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             w_pop;

  assign w_pop = pop && (r_count != 2'd0);
  assign dout  = r_mem[r_rptr];
  assign empty = (r_count == 2'd0);
  assign count = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, push} - {1'b0, w_pop};
    end
  end
endmodule

// File: rtl/fcc_window_scanner.sv
// Raster-scans the FCC point memory and streams (centre, left, up[, upleft]) windows.
// Define FCC_DIAG_EN to build the diagonal (up-left) neighbour for 8-connectivity.
module fcc_window_scanner #(
  parameter int ROWS    = 30,
  parameter int COLS    = 30,
  parameter int COL_W   = 5,
  parameter int LABEL_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           rd_row,
  output logic [COL_W-1:0]     rd_col,
  input  logic [LABEL_W-1:0]   rd_label,
  input  logic                 rd_is_ground,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_row,
  output logic [COL_W-1:0]     out_col,
  output logic [LABEL_W-1:0]   out_label,
  output logic                 out_is_ground,
  output logic [LABEL_W-1:0]   out_left,
  output logic [LABEL_W-1:0]   out_up,
  output logic [LABEL_W-1:0]   out_upleft,
  output logic                 out_last,
  output fcc_pkg::scan_state_e o_dbg_state
);
  localparam int DW = 8 + COL_W + LABEL_W + 1;

  // Stream contract: a window transfers on any cycle with out_valid & out_ready;
  // once out_valid rises, every out_* field holds until that transfer.
  fcc_pkg::scan_state_e r_state, w_next;
  logic               r_done;
  logic               r_inflight;
  logic [7:0]         r_tag_row;
  logic [COL_W-1:0]   r_tag_col;
  logic [LABEL_W-1:0] r_lb [COLS];
  logic [LABEL_W-1:0] r_left;
  logic [DW-1:0]      w_head;
  logic [1:0]         w_count;
  logic               w_empty;
  logic               w_hs;
  logic               w_accept;
  logic               w_issue;
  logic               w_room;
  logic               w_last_addr;
  logic [LABEL_W-1:0] w_masked;

  assign w_hs        = out_valid && out_ready;
  assign w_accept    = (r_state == fcc_pkg::ST_IDLE) && start && !r_done;
  assign w_last_addr = (rd_row == 8'(ROWS - 1)) && (rd_col == COL_W'(COLS - 1));
  // Occupancy after this cycle's pop plus the read already returning must leave a slot.
  assign w_room      = ({1'b0, w_count} + {2'b0, r_inflight}) <= (3'd1 + {2'b0, w_hs});
  assign w_issue     = w_accept || ((r_state == fcc_pkg::ST_SCAN) && w_room);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      fcc_pkg::ST_IDLE:  if (w_accept) w_next = w_last_addr ? fcc_pkg::ST_DRAIN : fcc_pkg::ST_SCAN;
      fcc_pkg::ST_SCAN:  if (w_issue && w_last_addr) w_next = fcc_pkg::ST_DRAIN;
      fcc_pkg::ST_DRAIN: if (w_hs && out_last) w_next = fcc_pkg::ST_IDLE;
      default:           w_next = fcc_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= fcc_pkg::ST_IDLE;
      r_done     <= 1'b0;
      r_inflight <= 1'b0;
      r_tag_row  <= '0;
      r_tag_col  <= '0;
      rd_row     <= '0;
      rd_col     <= '0;
    end else begin
      r_state    <= w_next;
      r_done     <= (r_state == fcc_pkg::ST_DRAIN) && w_hs && out_last;
      r_inflight <= w_issue;
      r_tag_row  <= rd_row;
      r_tag_col  <= rd_col;
      if (w_issue) begin
        if (rd_col == COL_W'(COLS - 1)) begin
          rd_col <= '0;
          rd_row <= (rd_row == 8'(ROWS - 1)) ? 8'd0 : rd_row + 8'd1;
        end else begin
          rd_col <= rd_col + COL_W'(1);
        end
      end
    end
  end

  fcc_skid_fifo #(.WIDTH(DW)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_inflight),
    .pop   (w_hs),
    .din   ({r_tag_row, r_tag_col, rd_label, rd_is_ground}),
    .dout  (w_head),
    .empty (w_empty),
    .count (w_count)
  );

  assign {out_row, out_col, out_label, out_is_ground} = w_head;
  assign out_valid = !w_empty;
  assign out_last  = out_valid && (out_row == 8'(ROWS - 1)) && (out_col == COL_W'(COLS - 1));
  assign w_masked  = out_is_ground ? '0 : out_label;
  // The line buffer still holds the previous frame's last row during row 0, so gate it.
  assign out_up    = (out_row == 8'd0) ? '0 : r_lb[out_col];
  assign out_left  = (out_col == '0) ? '0 : r_left;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < COLS; i++) r_lb[i] <= '0;
      r_left <= '0;
    end else if (w_hs) begin
      r_lb[out_col] <= w_masked;
      r_left        <= w_masked;
    end
  end

`ifdef FCC_DIAG_EN
  logic [LABEL_W-1:0] r_diag;

  always_ff @(posedge clk) begin
    if (!rst_n) r_diag <= '0;
    else if (w_hs) r_diag <= r_lb[out_col];
  end

  assign out_upleft = ((out_row == 8'd0) || (out_col == '0)) ? '0 : r_diag;
`else
  assign out_upleft = '0;
`endif

  assign busy        = (r_state != fcc_pkg::ST_IDLE);
  assign done        = r_done;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_fcc_window_scanner.sv
// Bench for fcc_window_scanner: a 3x3 and a 30x30 instance against a raster-order window model.
module tb_fcc_window_scanner;
  import fcc_pkg::*;

  typedef struct packed {
    logic [7:0]         row;
    logic [COL_W-1:0]   col;
    logic [LABEL_W-1:0] label;
    logic               gnd;
    logic [LABEL_W-1:0] left;
    logic [LABEL_W-1:0] up;
    logic [LABEL_W-1:0] upleft;
    logic               last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b1;
  int   sel = 0;
  int   ready_mode = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic               busy_v [2], done_v [2], out_valid_v [2], out_gnd_v [2], out_last_v [2], start_v [2];
  logic [7:0]         rd_row_v [2], out_row_v [2];
  logic [COL_W-1:0]   rd_col_v [2], out_col_v [2];
  logic [LABEL_W-1:0] rd_label_v [2], out_label_v [2], out_left_v [2], out_up_v [2], out_upleft_v [2];
  logic               rd_gnd_v [2];
  scan_state_e        dbg_v [2];

  logic               busy, done, out_valid, out_is_ground, out_last;
  logic [7:0]         out_row;
  logic [COL_W-1:0]   out_col;
  logic [LABEL_W-1:0] out_label, out_left, out_up, out_upleft;

  logic [LABEL_W-1:0] lab [30][30];
  logic               gnd [30][30];
  int                 a_r [2], a_c [2];

  exp_t exp_q [$];
  exp_t act, prev;
  bit   stall = 0;
  bit   last_hs = 0;
  int   hs_count = 0;
  int   done_cnt = 0;
  int   last_cnt = 0;
  logic [LABEL_W-1:0] seen_label [30][30], seen_left [30][30], seen_up [30][30], seen_upleft [30][30];
  logic               seen_gnd [30][30];
  int                 seen_cyc [30][30];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign start_v[0] = start && (sel == 0);
  assign start_v[1] = start && (sel == 1);
  assign busy          = busy_v[sel];
  assign done          = done_v[sel];
  assign out_valid     = out_valid_v[sel];
  assign out_is_ground = out_gnd_v[sel];
  assign out_last      = out_last_v[sel];
  assign out_row       = out_row_v[sel];
  assign out_col       = out_col_v[sel];
  assign out_label     = out_label_v[sel];
  assign out_left      = out_left_v[sel];
  assign out_up        = out_up_v[sel];
  assign out_upleft    = out_upleft_v[sel];

  fcc_window_scanner #(.ROWS(3), .COLS(3), .COL_W(COL_W), .LABEL_W(LABEL_W)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .rd_row(rd_row_v[0]), .rd_col(rd_col_v[0]), .rd_label(rd_label_v[0]), .rd_is_ground(rd_gnd_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_row(out_row_v[0]), .out_col(out_col_v[0]),
    .out_label(out_label_v[0]), .out_is_ground(out_gnd_v[0]), .out_left(out_left_v[0]),
    .out_up(out_up_v[0]), .out_upleft(out_upleft_v[0]), .out_last(out_last_v[0]), .o_dbg_state(dbg_v[0])
  );

  fcc_window_scanner #(.ROWS(30), .COLS(30), .COL_W(COL_W), .LABEL_W(LABEL_W)) dut30 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .rd_row(rd_row_v[1]), .rd_col(rd_col_v[1]), .rd_label(rd_label_v[1]), .rd_is_ground(rd_gnd_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_row(out_row_v[1]), .out_col(out_col_v[1]),
    .out_label(out_label_v[1]), .out_is_ground(out_gnd_v[1]), .out_left(out_left_v[1]),
    .out_up(out_up_v[1]), .out_upleft(out_upleft_v[1]), .out_last(out_last_v[1]), .o_dbg_state(dbg_v[1])
  );

  // Synchronous-read memory: address seen in a cycle returns data in the next cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      a_r[i] = int'(rd_row_v[i]);
      a_c[i] = int'(rd_col_v[i]);
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (a_r[i] < 30 && a_c[i] < 30) begin
        rd_label_v[i] = lab[a_r[i]][a_c[i]];
        rd_gnd_v[i]   = gnd[a_r[i]][a_c[i]];
      end else begin
        rd_label_v[i] = '0;
        rd_gnd_v[i]   = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = (ready_mode != 0) ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic chk_eq(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [LABEL_W-1:0] masked(input int r, input int c);
    return gnd[r][c] ? '0 : lab[r][c];
  endfunction

  task automatic build_expected(input int nr, input int nc);
    exp_t e;
    exp_q.delete();
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < nc; c++) begin
        e.row   = 8'(r);
        e.col   = COL_W'(c);
        e.label = lab[r][c];
        e.gnd   = gnd[r][c];
        e.left  = (c == 0) ? '0 : masked(r, c - 1);
        e.up    = (r == 0) ? '0 : masked(r - 1, c);
`ifdef FCC_DIAG_EN
        e.upleft = (r == 0 || c == 0) ? '0 : masked(r - 1, c - 1);
`else
        e.upleft = '0;
`endif
        e.last  = (r == nr - 1) && (c == nc - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Compare process: every window against the model, stall stability, done timing.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall   = 0;
      last_hs = 0;
    end else begin
      act = '{row: out_row, col: out_col, label: out_label, gnd: out_is_ground, left: out_left,
              up: out_up, upleft: out_upleft, last: out_last};
      chk_eq("done_timing", done, last_hs);
      if (done) done_cnt++;
      if (stall) chk_eq("stall_hold", {out_valid, act}, {1'b1, prev});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk_eq("extra_window", {out_row, out_col}, '1);
        end else begin
          chk_eq($sformatf("window(%0d,%0d)", exp_q[0].row, exp_q[0].col), act, exp_q[0]);
          if (out_ready) begin
            if (out_row < 30 && out_col < 30) begin
              seen_label[out_row][out_col]  = out_label;
              seen_gnd[out_row][out_col]    = out_is_ground;
              seen_left[out_row][out_col]   = out_left;
              seen_up[out_row][out_col]     = out_up;
              seen_upleft[out_row][out_col] = out_upleft;
              seen_cyc[out_row][out_col]    = cyc;
            end
            if (out_last) last_cnt++;
            void'(exp_q.pop_front());
            hs_count++;
          end
        end
      end
      last_hs = out_valid && out_ready && out_last;
      stall   = out_valid && !out_ready;
      prev    = act;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit got = 0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk); #1;
      got = done;
    end
    if (!got) chk_eq("timeout_done", 0, 1);
  endtask

  task automatic wait_hs(input int n, input int limit);
    bit got = 0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk); #1;
      got = (hs_count >= n);
    end
    if (!got) chk_eq("timeout_windows", hs_count, n);
  endtask

  task automatic fill_small(input bit ground_01);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        lab[r][c] = LABEL_W'(r * 3 + c + 1);
        gnd[r][c] = 1'b0;
      end
    gnd[0][1] = ground_01;
  endtask

  task automatic fill_random();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 30; c++) begin
        lab[r][c] = LABEL_W'($urandom_range(1, 65535));
        gnd[r][c] = ($urandom_range(0, 99) < 20);
      end
  endtask

  initial begin
    int sc;
    int d0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 30; c++) begin
        lab[r][c] = '0;
        gnd[r][c] = 1'b0;
      end

    // Reset held for two clocks.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk_eq("reset_busy", busy_v[i], 0);
      chk_eq("reset_valid", out_valid_v[i], 0);
      chk_eq("reset_rd_row", rd_row_v[i], 0);
      chk_eq("reset_rd_col", rd_col_v[i], 0);
      chk_eq("reset_state", dbg_v[i], ST_IDLE);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // 3x3, no ground, always ready.
    sel = 0; ready_mode = 0;
    fill_small(1'b0);
    build_expected(3, 3);
    hs_count = 0; last_cnt = 0; done_cnt = 0;
    @(posedge clk); #1 start = 1'b1; sc = cyc;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); #1;
    chk_eq("busy_after_start", busy, 1);
    chk_eq("valid_early", out_valid, 0);
    @(negedge clk); #1;
    chk_eq("first_valid_at_2", out_valid, 1);
    begin
      bit got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
        @(negedge clk); #1;
        got = last_hs;
      end
      if (!got) chk_eq("timeout_last", 0, 1);
    end
    // Start asserted in the same cycle as done must be ignored.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); #1;
    chk_eq("start_with_done_ignored", busy, 0);
    chk_eq("small_count", hs_count, 9);
    chk_eq("small_done_once", done_cnt, 1);
    chk_eq("small_last_once", last_cnt, 1);
    chk_eq("first_window_cycle", seen_cyc[0][0] - sc, 2);
    chk_eq("back_to_back", seen_cyc[2][2] - seen_cyc[0][0], 8);
    chk_eq("w11_left", seen_left[1][1], 4);
    chk_eq("w11_up", seen_up[1][1], 2);
`ifdef FCC_DIAG_EN
    chk_eq("w22_upleft", seen_upleft[2][2], 5);
`else
    chk_eq("w22_upleft", seen_upleft[2][2], 0);
`endif
    chk_eq("w10_upleft", seen_upleft[1][0], 0);

    // 3x3 with ground at (0,1).
    fill_small(1'b1);
    build_expected(3, 3);
    hs_count = 0;
    pulse_start();
    wait_done(100);
    chk_eq("gnd_count", hs_count, 9);
    chk_eq("gnd_w11_up", seen_up[1][1], 0);
    chk_eq("gnd_w02_left", seen_left[0][2], 0);
    chk_eq("gnd_w01_label", seen_label[0][1], 2);
    chk_eq("gnd_w01_flag", seen_gnd[0][1], 1);

    // 30x30, random data, 30% ready, extra start mid-scan.
    sel = 1; ready_mode = 1;
    repeat (3) @(posedge clk);
    fill_random();
    build_expected(30, 30);
    hs_count = 0; d0 = done_cnt;
    pulse_start();
    wait_hs(50, 2000);
    pulse_start();
    wait_done(20000);
    @(negedge clk); #1;
    chk_eq("big_count", hs_count, 900);
    chk_eq("big_queue_empty", exp_q.size(), 0);
    chk_eq("big_done_once", done_cnt - d0, 1);

    // Reset at window 100, then a fresh full scan.
    fill_random();
    build_expected(30, 30);
    hs_count = 0; d0 = done_cnt;
    pulse_start();
    wait_hs(100, 2000);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk_eq("abort_valid", out_valid, 0);
    chk_eq("abort_busy", busy, 0);
    chk_eq("abort_done", done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk_eq("abort_no_done", done_cnt - d0, 0);
    build_expected(30, 30);
    hs_count = 0;
    pulse_start();
    wait_done(20000);
    @(negedge clk); #1;
    chk_eq("rescan_count", hs_count, 900);
    chk_eq("rescan_queue_empty", exp_q.size(), 0);
    chk_eq("rescan_w00_label", seen_label[0][0], lab[0][0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
